// File: rtl/acc_cpu_pkg.sv
// Shared opcode and state encodings for the accumulator core.
package acc_cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_NOT = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB,
    OP_SHL = 4'hC, OP_SHR = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT
  } state_t;

endpackage

// File: rtl/acc_cpu_core_alu.sv
// Combinational ALU; opcodes that do not touch acc pass it through with carry held.
import acc_cpu_pkg::*;

module acc_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] m,
  input  opcode_t          opcode,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             z
);

  always_comb begin
    result = acc;
    c_out  = c_in;
    case (opcode)
      OP_LDA: result = m;
      OP_ADD: {c_out, result} = {1'b0, acc} + {1'b0, m};
      // borrow lands in the extra top bit exactly when acc < m
      OP_SUB: {c_out, result} = {1'b0, acc} - {1'b0, m};
      OP_AND: result = acc & m;
      OP_OR:  result = acc | m;
      OP_XOR: result = acc ^ m;
      OP_NOT: result = ~acc;
      OP_SHL: begin
        c_out  = acc[WIDTH-1];
        result = {acc[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        c_out  = acc[0];
        result = {1'b0, acc[WIDTH-1:1]};
      end
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU: single-port RAM, ALU and a 3-cycle fetch/decode/execute sequencer.
import acc_cpu_pkg::*;

module acc_cpu_core #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  output logic [WIDTH-1:0]  dbg_data,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [WIDTH-1:0]  acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic [WIDTH-1:0]  out_data
);

  state_t             state;
  logic [WIDTH-1:0]   ir;
  logic [WIDTH-1:0]   ram_q;
  logic [ADDR_W-1:0]  ram_addr;
  logic [WIDTH-1:0]   mem [2**ADDR_W];
  opcode_t            op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_c;
  logic               alu_z;
  logic               idle_like;

  assign op        = opcode_t'(ir[WIDTH-1 -: OPC_W]);
  assign idle_like = (state == ST_IDLE) || (state == ST_HALT);
  assign busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign halted    = (state == ST_HALT);
  assign dbg_data  = ram_q;

  // In DECODE the instruction is still only on ram_q, so its operand field drives the address
  always_comb begin
    case (state)
      ST_FETCH:  ram_addr = pc;
      ST_DECODE: ram_addr = ram_q[ADDR_W-1:0];
      ST_EXEC:   ram_addr = ir[ADDR_W-1:0];
      default:   ram_addr = load_addr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (idle_like && load_en)
        mem[load_addr] <= load_data;
      else if (state == ST_EXEC && op == OP_STA)
        mem[ram_addr] <= acc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ram_q <= '0;
    else       ram_q <= mem[ram_addr];
  end

  acc_alu #(.WIDTH(WIDTH)) u_alu (
    .acc    (acc),
    .m      (ram_q),
    .opcode (op),
    .c_in   (flag_c),
    .result (alu_result),
    .c_out  (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      acc      <= '0;
      ir       <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state  <= ST_FETCH;
            pc     <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
          end
        end
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= ram_q;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          pc    <= pc + 1'b1;
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
              acc    <= alu_result;
              flag_z <= alu_z;
              flag_c <= alu_c;
            end
            OP_JMP: pc <= ir[ADDR_W-1:0];
            OP_JZ:  if (flag_z) pc <= ir[ADDR_W-1:0];
            OP_JC:  if (flag_c) pc <= ir[ADDR_W-1:0];
            OP_OUT: out_data <= acc;
            OP_HLT: begin
              state <= ST_HALT;
              pc    <= pc;
            end
            default: ;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed-program bench for acc_cpu_core with hand-computed expected results.
module tb_acc_cpu_core;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] dbg_data;
  logic       start;
  logic       busy;
  logic       halted;
  logic [3:0] pc;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic [7:0] out_data;

  logic [7:0] img [16];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc;
  logic [7:0] rd;

  acc_cpu_core #(.WIDTH(8), .ADDR_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .dbg_data  (dbg_data),
    .start     (start),
    .busy      (busy),
    .halted    (halted),
    .pc        (pc),
    .acc       (acc),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic load_image();
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = 4'(i);
      load_data = img[i];
      tick(1);
    end
    load_en = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    load_addr = a;
    tick(1);
    d = dbg_data;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 100) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    tick(2);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_dbg", dbg_data, 0);
    chk("rst_out", out_data, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    reset = 1'b0;
    tick(1);

    // LDA 14; ADD 15; STA 13; OUT; HLT  with 5 + 7
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'h2D; img[3] = 8'hE0; img[4] = 8'hF0;
    img[14] = 8'h05; img[15] = 8'h07;
    load_image();
    pulse_start();
    chk("p1_busy", busy, 1);
    wait_halt(cyc);
    chk("p1_cycles", cyc, 15);
    chk("p1_out", out_data, 8'h0C);
    chk("p1_acc", acc, 8'h0C);
    chk("p1_flags", {flag_z, flag_c}, 2'b00);
    chk("p1_pc", pc, 4);
    chk("p1_busy_end", busy, 0);
    peek(4'd13, rd);
    chk("p1_mem13", rd, 8'h0C);

    // FF + 01 wraps to 00 with carry; JC 6 taken
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'hB6; img[3] = 8'hF0; img[6] = 8'hF0;
    img[14] = 8'hFF; img[15] = 8'h01;
    load_image();
    pulse_start();
    wait_halt(cyc);
    chk("p2_cycles", cyc, 12);
    chk("p2_acc", acc, 8'h00);
    chk("p2_flags", {flag_z, flag_c}, 2'b11);
    chk("p2_pc", pc, 6);

    // 03-05 borrow, SHR, AND with zero
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h4F; img[2] = 8'hD0; img[3] = 8'h5D; img[4] = 8'hF0;
    img[13] = 8'h00; img[14] = 8'h03; img[15] = 8'h05;
    load_image();
    pulse_start();
    tick(6);
    chk("p3_sub_acc", acc, 8'hFE);
    chk("p3_sub_flags", {flag_z, flag_c}, 2'b01);
    tick(3);
    chk("p3_shr_acc", acc, 8'h7F);
    chk("p3_shr_flags", {flag_z, flag_c}, 2'b00);
    tick(3);
    chk("p3_and_acc", acc, 8'h00);
    chk("p3_and_flags", {flag_z, flag_c}, 2'b10);
    wait_halt(cyc);
    chk("p3_cycles", cyc, 3);

    // JZ 3 falls through, LDA zero, JMP 15, NOP at 15 wraps to 0, JZ 3 taken
    clear_img();
    img[0] = 8'hA3; img[1] = 8'h1E; img[2] = 8'h9F; img[3] = 8'hF0;
    load_image();
    pulse_start();
    tick(3);
    chk("p4_jz_not_taken", pc, 1);
    tick(6);
    chk("p4_jmp15", pc, 15);
    tick(3);
    chk("p4_wrap_pc", pc, 0);
    chk("p4_pc_known", $isunknown(pc), 0);
    wait_halt(cyc);
    chk("p4_cycles", cyc, 6);
    chk("p4_pc_end", pc, 3);

    // load_en/start while busy must be ignored
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'h2D; img[3] = 8'hE0; img[4] = 8'hF0;
    img[14] = 8'h05; img[15] = 8'h07;
    load_image();
    pulse_start();
    tick(4);
    load_en = 1'b1; load_addr = 4'd0; load_data = 8'hF0; start = 1'b1;
    tick(3);
    load_en = 1'b0; start = 1'b0;
    wait_halt(cyc);
    chk("p5_cycles", cyc, 8);
    chk("p5_pc", pc, 4);
    chk("p5_out", out_data, 8'h0C);
    peek(4'd0, rd);
    chk("p5_mem0", rd, 8'h1E);

    // reset sampled in the EXEC cycle of STA 13
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2D; img[13] = 8'hAA; img[14] = 8'h05;
    load_image();
    pulse_start();
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("p6_busy", busy, 0);
    chk("p6_halted", halted, 0);
    chk("p6_pc", pc, 0);
    chk("p6_acc", acc, 0);
    chk("p6_out", out_data, 0);
    chk("p6_dbg", dbg_data, 0);
    chk("p6_flags", {flag_z, flag_c}, 0);
    reset = 1'b0;
    peek(4'd13, rd);
    chk("p6_mem13", rd, 8'hAA);
    chk("p6_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
